// File: rtl/program_loader_if.sv
// Loader-side bus: byte stream in, instruction-memory init port and status out.
// The slave modport is the loader's view; master is the system/stream side.
interface program_loader_if #(
  parameter int ADDR_W = 12
) ();
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              init_mode;
  logic [ADDR_W-1:0] init_address;
  logic [31:0]       init_instruction;
  logic              write_enable;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       word_count;

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, init_mode, init_address, init_instruction,
           write_enable, busy, done, error, word_count
  );

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, init_mode, init_address, init_instruction,
           write_enable, busy, done, error, word_count
  );
endinterface

// File: rtl/program_loader.sv
// Length-prefixed byte-stream loader: assembles big-endian 32-bit words and
// writes them into instruction memory through its init port.
module program_loader #(
  parameter int DEPTH   = 4096,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  program_loader_if.slave   bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t            r_state, w_next;
  logic [23:0]       r_word;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W:0]   r_widx;
  logic [TW-1:0]     r_timer;
  logic [15:0]       r_word_count;
  logic [ADDR_W-1:0] r_init_address;
  logic [31:0]       r_init_instruction;

  logic        w_rx_ready, w_xfer, w_timeout, w_last, w_idle_like;
  logic [15:0] w_n;

  assign w_rx_ready  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_DATA);
  assign w_xfer      = bus.rx_valid && w_rx_ready;
  assign w_timeout   = !w_xfer && (r_timer == TW'(TIMEOUT - 1));
  assign w_n         = {r_word_count[15:8], bus.rx_data};
  // Index is one bit wider than the address so N = DEPTH completes before wrapping
  assign w_last      = (32'(r_widx) + 32'd1) == 32'(r_word_count);
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (bus.start) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_xfer)         w_next = S_LEN_LO;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_LEN_LO: begin
        if (w_xfer) begin
          if (w_n == 16'd0)                 w_next = S_DONE;
          else if (32'(w_n) > 32'(DEPTH))   w_next = S_ERROR;
          else                              w_next = S_DATA;
        end else if (w_timeout) begin
          w_next = S_ERROR;
        end
      end
      S_DATA: begin
        if (w_xfer && r_byte_cnt == 2'd3) w_next = S_WRITE;
        else if (w_timeout)               w_next = S_ERROR;
      end
      S_WRITE: w_next = w_last ? S_DONE : S_DATA;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state            <= S_IDLE;
      r_word             <= '0;
      r_byte_cnt         <= '0;
      r_widx             <= '0;
      r_timer            <= '0;
      r_word_count       <= '0;
      r_init_address     <= '0;
      r_init_instruction <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle_like && bus.start) begin
        r_byte_cnt <= '0;
        r_widx     <= '0;
        r_timer    <= '0;
      end
      if (w_rx_ready) begin
        if (w_xfer) r_timer <= '0;
        else        r_timer <= r_timer + TW'(1);
      end
      if (w_xfer && r_state == S_LEN_HI) r_word_count[15:8] <= bus.rx_data;
      if (w_xfer && r_state == S_LEN_LO) r_word_count[7:0]  <= bus.rx_data;
      if (w_xfer && r_state == S_DATA) begin
        r_word     <= {r_word[15:0], bus.rx_data};
        r_byte_cnt <= r_byte_cnt + 2'd1;
        // Latch the write port on the 4th byte so it is stable through WRITE
        if (r_byte_cnt == 2'd3) begin
          r_init_address     <= r_widx[ADDR_W-1:0];
          r_init_instruction <= {r_word, bus.rx_data};
        end
      end
      if (r_state == S_WRITE) r_widx <= r_widx + 1'b1;
    end
  end

  assign bus.rx_ready         = w_rx_ready;
  assign bus.init_mode        = w_rx_ready || (r_state == S_WRITE);
  assign bus.busy             = bus.init_mode;
  assign bus.write_enable     = (r_state == S_WRITE);
  assign bus.done             = (r_state == S_DONE);
  assign bus.error            = (r_state == S_ERROR);
  assign bus.init_address     = r_init_address;
  assign bus.init_instruction = r_init_instruction;
  assign bus.word_count       = r_word_count;
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: byte-count based reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_program_loader;
  localparam int DEPTH = 4096;
  localparam int ADDR_W = 12;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();
  program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks progress by bytes accepted since start, not by state.
  bit          m_active, m_wr, m_done, m_err;
  int          m_bytes, m_N, m_widx, m_idle;
  logic [31:0] m_cur, m_data;
  logic [11:0] m_addr;
  logic [15:0] m_wc;

  always @(posedge clk) begin
    logic [7:0] d;
    d = bus.rx_data;
    if (!rst_n) begin
      m_active = 0; m_wr = 0; m_done = 0; m_err = 0;
      m_bytes = 0; m_N = 0; m_widx = 0; m_idle = 0;
      m_cur = '0; m_data = '0; m_addr = '0; m_wc = '0;
    end else if (m_wr) begin
      m_wr = 0;
      m_widx++;
      if (m_widx == m_N) begin m_active = 0; m_done = 1; end
    end else if (m_active) begin
      if (bus.rx_valid) begin
        m_idle = 0;
        m_bytes++;
        if (m_bytes == 1) m_wc[15:8] = d;
        else if (m_bytes == 2) begin
          m_wc[7:0] = d;
          m_N = int'(m_wc);
          if (m_N == 0) begin m_active = 0; m_done = 1; end
          else if (m_N > DEPTH) begin m_active = 0; m_err = 1; end
        end else begin
          m_cur = {m_cur[23:0], d};
          if ((m_bytes - 2) % 4 == 0) begin
            m_wr = 1; m_addr = m_widx[11:0]; m_data = m_cur;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin m_active = 0; m_err = 1; end
      end
    end else if (bus.start) begin
      m_active = 1; m_done = 0; m_err = 0;
      m_bytes = 0; m_widx = 0; m_idle = 0;
    end
    #1;
    check("cycle_outputs",
      {bus.rx_ready, bus.init_mode, bus.busy, bus.write_enable, bus.done, bus.error,
       bus.init_address, bus.init_instruction, bus.word_count},
      {m_active && !m_wr, m_active, m_active, m_wr, m_done, m_err,
       m_addr, m_data, m_wc});
  end

  // Memory image as the DUT writes it
  logic [31:0] mem [DEPTH];
  int wr_cnt = 0;
  int last_addr = -1;
  always @(negedge clk) begin
    if (bus.write_enable) begin
      mem[bus.init_address] = bus.init_instruction;
      wr_cnt++;
      last_addr = int'(bus.init_address);
    end
  end

  // All drivers run at negedges
  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    int gap;
    bit ok;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (bus.rx_ready) ok = 1;
      @(negedge clk);
    end
    if (!ok) check("byte_accept_timeout", 80'd0, 80'd1);
  endtask

  task automatic send_stream(input logic [7:0] q[$], input int maxgap);
    foreach (q[i]) send(q[i], maxgap);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int k;
    k = 0;
    while (bus.busy && k < budget) begin @(negedge clk); k++; end
    check("busy_drop", 80'(bus.busy), 80'd0);
  endtask

  logic [31:0] exp_words[$];

  // Random-content load of n words; checks memory image and write count
  task automatic run_load(input int n, input int maxgap);
    logic [7:0] q[$];
    int base, bad;
    q = {};
    exp_words = {};
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      exp_words.push_back($urandom);
      for (int j = 3; j >= 0; j--) q.push_back(exp_words[i][8*j +: 8]);
    end
    base = wr_cnt;
    do_start();
    send_stream(q, maxgap);
    wait_quiet(200);
    bad = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== exp_words[i]) bad++;
    check("load_mem_bad_words", 80'(bad), 80'd0);
    check("load_write_count", 80'(wr_cnt - base), 80'(n));
    check("load_done", 80'({bus.done, bus.error}), 80'b10);
  endtask

  logic [7:0] normal[$];

  initial begin
    int base, k;
    bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    normal = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    repeat (3) @(negedge clk);
    check("reset_outputs",
      {bus.rx_ready, bus.init_mode, bus.busy, bus.write_enable, bus.done, bus.error,
       bus.init_address, bus.init_instruction, bus.word_count}, 80'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal load, valid held high
    base = wr_cnt;
    do_start();
    check("start_ready", 80'({bus.rx_ready, bus.init_mode}), 80'b11);
    send_stream(normal, 0);
    wait_quiet(50);
    check("normal_mem0", 80'(mem[0]), 80'h DEADBEEF);
    check("normal_mem1", 80'(mem[1]), 80'h12345678);
    check("normal_writes", 80'(wr_cnt - base), 80'd2);
    check("normal_status", 80'({bus.done, bus.init_mode, bus.word_count}), {62'd0, 2'b10, 16'd2});

    // N = 0 and N = DEPTH+1 headers
    base = wr_cnt;
    do_start();
    send_stream('{8'h00, 8'h00}, 0);
    @(negedge clk);
    check("n0_done", 80'({bus.done, bus.error, bus.busy}), 80'b100);
    check("n0_writes", 80'(wr_cnt - base), 80'd0);
    do_start();
    send_stream('{8'h10, 8'h01}, 0);
    @(negedge clk);
    check("nbig_error", 80'({bus.done, bus.error, bus.word_count}), {62'd0, 2'b01, 16'h1001});
    check("nbig_writes", 80'(wr_cnt - base), 80'd0);

    // Scramble memory, then gapped replay of the normal stream
    run_load(2, 3);
    base = wr_cnt;
    do_start();
    send_stream(normal, 12);
    wait_quiet(100);
    check("gap_mem0", 80'(mem[0]), 80'h DEADBEEF);
    check("gap_mem1", 80'(mem[1]), 80'h12345678);
    check("gap_writes", 80'(wr_cnt - base), 80'd2);

    // Random loads with random gaps
    for (int r = 0; r < 4; r++) run_load(int'($urandom_range(6, 1)), 14);

    // Timeout after 3 data bytes of word 1
    do_start();
    send_stream('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC}, 0);
    k = 0;
    while (!bus.error && k < 40) begin @(negedge clk); k++; end
    check("timeout_cycles", 80'(k), 80'd16);
    check("timeout_status", 80'({bus.error, bus.init_mode}), 80'b10);
    check("timeout_keeps_mem0", 80'(mem[0]), 80'h11223344);
    do_start();
    check("restart_clears_error", 80'(bus.error), 80'd0);
    send_stream(normal, 0);
    wait_quiet(50);
    check("reload_mem1", 80'(mem[1]), 80'h12345678);

    // start while busy is ignored; start while done restarts at address 0
    do_start();
    send_stream('{8'h00, 8'h01, 8'hAA, 8'hBB}, 0);
    do_start();
    send_stream('{8'hCC, 8'hDD}, 0);
    wait_quiet(50);
    check("busy_start_ignored", 80'(mem[0]), 80'h AABBCCDD);
    do_start();
    check("done_clears", 80'({bus.done, bus.busy}), 80'b01);
    send_stream('{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D}, 0);
    wait_quiet(50);
    check("restart_addr0", 80'({last_addr[11:0], mem[0]}), {36'd0, 12'h000, 32'hCAFEF00D});

    // Reset in the middle of a word
    base = wr_cnt;
    do_start();
    send_stream('{8'h00, 8'h01, 8'h55, 8'h66}, 0);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h77;
    rst_n = 1'b0;
    @(negedge clk);
    check("midload_reset_outputs",
      {bus.rx_ready, bus.init_mode, bus.busy, bus.write_enable, bus.done, bus.error,
       bus.init_address, bus.init_instruction, bus.word_count}, 80'd0);
    rst_n = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midload_no_write", 80'(wr_cnt - base), 80'd0);

    // Full depth
    run_load(DEPTH, 0);
    check("full_last_addr", 80'(last_addr), 80'h FFF);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end
endmodule
